// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared types and constants for the sequential BCD-to-binary path.
// Revision: 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  DIGIT_MAX   = 4'd9;
    localparam logic [3:0]  CORR_THRESH = 4'd8;

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_rdd_step.sv
`default_nettype none
// ============================================================================
// Module  : bcd_rdd_step
// Brief   : One reverse double-dabble step: shift {bcd,bin} right, then -3 on
//           every shifted digit that reached 8 or more.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_rdd_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    input  logic [BIN_W-1:0]              bin_in,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic [BIN_W-1:0]              bin_out
);

    localparam int c_bcd_w = BCD_DIGIT_W * DIGITS;

    logic [c_bcd_w-1:0] w_bcd_sh;

    assign w_bcd_sh = {1'b0, bcd_in[c_bcd_w-1:1]};
    assign bin_out  = {bcd_in[0], bin_in[BIN_W-1:1]};

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            logic [BCD_DIGIT_W-1:0] w_dig;
            assign w_dig = w_bcd_sh[g*BCD_DIGIT_W +: BCD_DIGIT_W];
            // a digit of 8+ after halving means a borrowed ten became 16/2
            assign bcd_out[g*BCD_DIGIT_W +: BCD_DIGIT_W] =
                (w_dig >= CORR_THRESH) ? (w_dig - 4'd3) : w_dig;
        end
    endgenerate

endmodule : bcd_rdd_step
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_bin_seq
// Brief   : Sequential BCD-to-binary converter, one shift/correct per clock,
//           with start/busy/done handshake and non-decimal digit flag.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [BIN_W-1:0]              bin_o
);

    localparam int     c_bcd_w   = BCD_DIGIT_W * DIGITS;
    localparam int     c_cnt_w   = $clog2(BIN_W + 1);
    localparam longint c_dec_max = pow10(DIGITS) - 1;
    localparam longint c_bin_max = (longint'(1) << BIN_W) - 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BIN_W - 1);

    generate
        if (c_bin_max < c_dec_max) begin : g_bad_width
            $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_bcd_w-1:0]   r_bcd_sr;
    logic [BIN_W-1:0]     r_bin_sr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_err_pend;
    logic                 r_done;
    logic                 r_err;
    logic [BIN_W-1:0]     r_bin;
    logic [c_bcd_w-1:0]   w_bcd_step;
    logic [BIN_W-1:0]     w_bin_step;
    logic [DIGITS-1:0]    w_digit_bad;
    logic                 w_any_bad;
    logic                 w_accept;
    logic                 w_step;
    logic                 w_finish;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_valid
            assign w_digit_bad[g] = (bcd_i[g*BCD_DIGIT_W +: BCD_DIGIT_W] > DIGIT_MAX);
        end
    endgenerate

    assign w_any_bad = |w_digit_bad;

    bcd_rdd_step #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_step (
        .bcd_in  (r_bcd_sr),
        .bin_in  (r_bin_sr),
        .bcd_out (w_bcd_step),
        .bin_out (w_bin_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_any_bad ? DONE : CONV;
                end
            end
            CONV: begin
                w_step = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd_sr   <= '0;
            r_bin_sr   <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_bin      <= '0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_bcd_sr   <= bcd_i;
                r_bin_sr   <= '0;
                r_cnt      <= '0;
                r_err_pend <= w_any_bad;
            end else if (w_step) begin
                r_bcd_sr <= w_bcd_step;
                r_bin_sr <= w_bin_step;
                r_cnt    <= r_cnt + 1'b1;
            end
            // results are published only here so they stay stable between pulses
            if (w_finish) begin
                r_err <= r_err_pend;
                r_bin <= r_err_pend ? '0 : r_bin_sr;
            end
        end
    end

    assign busy_o = (r_state == CONV);
    assign done_o = r_done;
    assign err_o  = r_err;
    assign bin_o  = r_bin;

endmodule : bcd_to_bin_seq
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_to_bin_seq
// Brief   : Self-checking bench for bcd_to_bin_seq (vectors, corner sequences,
//           exhaustive valid sweep and random words against a decimal model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;

    localparam int DIGITS  = 3;
    localparam int BIN_W   = 10;
    localparam int LAT_OK  = BIN_W + 2;
    localparam int LAT_ERR = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   start_i;
    logic [4*DIGITS-1:0]    bcd_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;
    logic [BIN_W-1:0]       bin_o;

    int n_checks = 0;
    int n_err    = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .bcd_i   (bcd_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .bin_o   (bin_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        int          exp_bin;
        int          exp_err;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // decimal reading of the packed word, straight from digit weights
    function automatic void ref_model(input logic [11:0] w, output int val, output int err);
        int d;
        int weight;
        val    = 0;
        err    = 0;
        weight = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((w >> (4 * i)) & 12'hF);
            if (d > 9) err = 1;
            val    = val + d * weight;
            weight = weight * 10;
        end
        if (err != 0) val = 0;
    endfunction

    // call at a negedge with the DUT idle; returns at the negedge showing done_o
    task automatic run_conv(input logic [11:0] w, output int lat, output int busy_cnt,
                            output int bin, output int err, output int sr_zero,
                            output int timeout);
        bit seen;
        start_i = 1'b1;
        bcd_i   = w;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        bcd_i    = 12'($urandom);
        lat      = 1;
        busy_cnt = 0;
        seen     = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (done_o) begin
                seen = 1;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        timeout = seen ? 0 : 1;
        bin     = int'(bin_o);
        err     = int'(err_o);
        sr_zero = (dut.r_bcd_sr == '0) ? 1 : 0;
    endtask

    initial begin
        int lat, busy_cnt, bin, err, sr_zero, timeout;
        int m_val, m_err, edge_n, ndone, extra, gap;
        logic [11:0] w;

        vecs[0] = '{12'h255, 255, 0, LAT_OK, BIN_W};
        vecs[1] = '{12'h999, 999, 0, LAT_OK, BIN_W};
        vecs[2] = '{12'h000,   0, 0, LAT_OK, BIN_W};
        vecs[3] = '{12'h0A5,   0, 1, LAT_ERR, 0};
        vecs[4] = '{12'h042,  42, 0, LAT_OK, BIN_W};
        vecs[5] = '{12'hF09,   0, 1, LAT_ERR, 0};
        vecs[6] = '{12'h909, 909, 0, LAT_OK, BIN_W};

        rst_n   = 1'b0;
        start_i = 1'b0;
        bcd_i   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_err",  err_o,  0);
        check("reset_bin",  bin_o,  0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy_o, 0);
        check("idle_done", done_o, 0);

        foreach (vecs[i]) begin
            run_conv(vecs[i].bcd, lat, busy_cnt, bin, err, sr_zero, timeout);
            check("vec_timeout", timeout, 0);
            check("vec_bin", bin, vecs[i].exp_bin);
            check("vec_err", err, vecs[i].exp_err);
            check("vec_latency", lat, vecs[i].exp_lat);
            check("vec_busy_cycles", busy_cnt, vecs[i].exp_busy);
            @(negedge clk);
            check("vec_done_width", done_o, 0);
            check("vec_bin_held", bin_o, vecs[i].exp_bin);
            check("vec_err_held", err_o, vecs[i].exp_err);
        end

        // start held high through CONV/DONE: re-accept only once back in IDLE
        start_i = 1'b1;
        bcd_i   = 12'h123;
        @(posedge clk);
        #1 bcd_i = 12'h456;
        edge_n = 1;
        ndone  = 0;
        for (int i = 0; i < 60 && ndone < 2; i++) begin
            @(negedge clk);
            if (done_o) begin
                ndone++;
                if (ndone == 1) begin
                    check("hold_first_bin",  bin_o, 123);
                    check("hold_first_edge", edge_n, LAT_OK);
                end else begin
                    check("hold_second_bin",  bin_o, 456);
                    check("hold_second_edge", edge_n, 2 * LAT_OK);
                    start_i = 1'b0;
                end
            end
            if (ndone < 2) begin
                @(posedge clk);
                edge_n++;
            end
        end
        check("hold_done_count", ndone, 2);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_o) extra++;
        end
        check("hold_no_extra_done", extra, 0);

        // reset in the middle of a conversion
        run_conv(12'hB00, lat, busy_cnt, bin, err, sr_zero, timeout);
        check("pre_reset_err", err, 1);
        @(negedge clk);
        start_i = 1'b1;
        bcd_i   = 12'h777;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("mid_conv_busy", busy_o, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy_o, 0);
        check("async_rst_done", done_o, 0);
        check("async_rst_err",  err_o,  0);
        check("async_rst_bin",  bin_o,  0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_o || busy_o) extra++;
        end
        check("rst_discard_no_done", extra, 0);
        run_conv(12'h001, lat, busy_cnt, bin, err, sr_zero, timeout);
        check("post_rst_timeout", timeout, 0);
        check("post_rst_bin", bin, 1);
        check("post_rst_lat", lat, LAT_OK);

        // every valid operand, random idle gaps
        for (int v = 0; v < 1000; v++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            w = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            ref_model(w, m_val, m_err);
            run_conv(w, lat, busy_cnt, bin, err, sr_zero, timeout);
            check("sweep_timeout", timeout, 0);
            check("sweep_bin", bin, m_val);
            check("sweep_err", err, m_err);
            check("sweep_bcd_sr_zero", sr_zero, 1);
            check("sweep_lat", lat, LAT_OK);
        end

        // arbitrary 12-bit words, valid or not
        for (int r = 0; r < 300; r++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            w = 12'($urandom);
            ref_model(w, m_val, m_err);
            run_conv(w, lat, busy_cnt, bin, err, sr_zero, timeout);
            check("rand_timeout", timeout, 0);
            check("rand_bin", bin, m_val);
            check("rand_err", err, m_err);
            check("rand_lat", lat, (m_err != 0) ? LAT_ERR : LAT_OK);
            if (m_err == 0) check("rand_bcd_sr_zero", sr_zero, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule : tb_bcd_to_bin_seq
`default_nettype wire

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter; the inverse of the team's combinational binary-to-BCD display path.
- Accepts a packed DIGITS-digit BCD word and produces the unsigned binary value using reverse double-dabble: one shift/correct step per clock.
- Sits between keypad/BCD entry logic and the arithmetic datapath.
- Uses a start/busy/done handshake and flags non-decimal digits.

Parameters:
- DIGITS, 3, number of BCD digits in the input. Digit 0 is bits [3:0], the least significant digit.
- BIN_W, 10, output width. Must satisfy 2^BIN_W > 10^DIGITS - 1; this is checked by an elaboration-time assertion.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  request conversion of bcd_i. Sampled only in IDLE.
- bcd_i  input  4*DIGITS  packed BCD operand
- busy_o  output  1  high while a conversion is in progress (CONV)
- done_o  output  1  one-cycle pulse when bin_o/err_o are updated
- err_o  output  1  at least one digit of the last accepted operand was greater than 9; held until the next accept
- bin_o  output  BIN_W  last result; held until the next done_o

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - busy_o = 0, done_o = 0, err_o = 0, bin_o = 0.
  - Internal shift registers = 0.
- States: IDLE, CONV, DONE.
- IDLE:
  - If start_i = 1 at edge k, capture bcd_i into bcd_sr (4*DIGITS bits), clear bin_sr (BIN_W bits), and clear the shift counter.
  - If every digit is 9 or less, go to CONV.
  - Otherwise go to DONE with err flagged and bin result forced to 0.
  - If start_i = 0, stay in IDLE.
- CONV: each edge performs one step.
  - Shift the concatenation {bcd_sr, bin_sr} right by 1. The bcd_sr LSB enters the bin_sr MSB.
  - Then, for each 4-bit digit of the shifted bcd_sr: if the digit is 8 or more, subtract 3.
  - Shift and correct are combinational within the same cycle.
  - The counter increments each step. After step BIN_W, go to DONE.
- DONE: this single state's registered outputs are done_o = 1, bin_o = bin_sr (or 0 on error), and err_o updated. Next state is always IDLE.
- Timing for a valid operand:
  - done_o is high in the cycle following edge k+BIN_W+1.
  - Start accept to done pulse is BIN_W+2 edges (12 for the defaults).
  - Invalid operand: done_o follows edge k+1.
- busy_o = 1 exactly while in CONV. Hence start_i is ignored in CONV and DONE; requests are not queued.
- A new start_i may be accepted in the first IDLE cycle after DONE. Back-to-back throughput is one conversion per BIN_W+2 cycles.
- bcd_i only needs to be stable at the accept edge. Later changes have no effect.
- All arithmetic is unsigned and no overflow is possible under the parameter constraint. After BIN_W steps bcd_sr must be 0; the bench asserts this.
- Reset asserted mid-CONV or in DONE: outputs return to reset values immediately and the in-flight conversion is discarded. No done_o is produced for it.
- err_o and bin_o change only at DONE, so they are stable between pulses.

Decomposition:
- Shared package bcd_pkg:
  - state enum typedef (IDLE, CONV, DONE);
  - localparam BCD_DIGIT_W = 4;
  - constants DIGIT_MAX = 9 and CORR_THRESH = 8.
- One natural sub-module, bcd_rdd_step: purely combinational, parameterised by DIGITS and BIN_W.
  - Inputs: {bcd_sr, bin_sr}.
  - Outputs: the shifted and corrected pair.
  - Unit-testable on its own.
- The top level holds the FSM, counter, digit-validity check and output registers.

Test Plan:
- Reset, then start with bcd_i = 12'h255 → busy_o high for 10 cycles; done_o pulse 12 edges after accept; bin_o = 10'd255; err_o = 0.
- bcd_i = 12'h999 → bin_o = 10'd999 (0x3E7). bcd_i = 12'h000 → bin_o = 0 with full latency.
- bcd_i = 12'h0A5 → done_o on the second edge after accept; err_o = 1; bin_o = 0. A following 12'h042 → err_o = 0, bin_o = 42.
- Start 12'h123, then hold start_i = 1 with bcd_i = 12'h456 throughout CONV/DONE → first result 123. The request is accepted again only once IDLE is reached, giving 456 one full latency later. Exactly one done_o per accept.
- Start 12'h777, deassert rst_n at CONV step 5 → all outputs 0 asynchronously and no done_o. After release, 12'h001 converts to 1.
- Sweep all 1000 valid values with random gaps between starts → bin_o matches the decimal value every time, and the internal bcd_sr is 0 at DONE.
